word_concatenator_stream: RTL and testbench
===========================================

Name: word_concatenator_stream

Overview:
- Streaming successor to word_concatenator. Packs up to MAX_WORDS input words of INPUT_WIDTH bits into one output word.
- Adds valid/ready backpressure on both sides and a runtime group length.
- Adds early group termination via last_i, with a per-slot keep mask on output.
- Sits between narrow byte/sample producers (UART, SPI, ADC front ends) and wide consumers (FIFOs, bus masters).

Parameters:
- INPUT_WIDTH, 8, width of one input word.
- MAX_WORDS, 4, maximum input words per output word; must be >= 1.
- ENDIAN, "little", "little": word k of a group lands at bits [k*INPUT_WIDTH +: INPUT_WIDTH]. "big": word k lands at bits [(MAX_WORDS-1-k)*INPUT_WIDTH +: INPUT_WIDTH].
- CNT_W, $clog2(MAX_WORDS+1), width of words_per_out_i.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- reset_n_i  input  1  asynchronous, active-low reset.
- words_per_out_i  input  CNT_W  runtime group length.
- data_i  input  INPUT_WIDTH  input word.
- data_valid_i  input  1  input beat valid.
- last_i  input  1  closes the current group after this beat; qualified by the input handshake.
- data_ready_o  output  1  block can accept data_i this cycle.
- accumulated_data_o  output  INPUT_WIDTH*MAX_WORDS  packed output word.
- accumulated_keep_o  output  MAX_WORDS  bit k set = slot k holds valid data, in group order, independent of ENDIAN.
- accumulated_data_valid_o  output  1  output valid.
- accumulated_data_ready_i  input  1  consumer accepts output.

Behaviour:
- Reset (reset_n_i low, asynchronous): accumulated_data_o=0, accumulated_keep_o=0, accumulated_data_valid_o=0, fill count=0, accumulator=0.
  - Reset asserted mid-group discards the partial group and any pending output.
  - data_ready_o is 0 while reset is asserted.
- Input handshake: a beat is accepted when data_valid_i && data_ready_o at the rising edge. data_i and last_i are ignored otherwise.
- Output handshake: the output transfers when accumulated_data_valid_o && accumulated_data_ready_i.
  - Output data, keep and valid are held stable while valid is high and ready is low.
- Group length target:
  - Latched from words_per_out_i on the first accepted beat of a group (count==0); ignored for the rest of the group.
  - Value 0 or > MAX_WORDS is treated as MAX_WORDS.
- Accumulator:
  - An accepted beat writes data_i into slot[count] and sets keep bit[count]; count increments.
  - Unwritten slots read as 0.
- Group completes on an accepted beat when count+1 == target or last_i=1.
  - Accumulator contents (including this beat) move to the output register on that edge.
  - accumulated_data_valid_o rises the next cycle; latency is 1 cycle from the completing beat.
  - On the same edge, count and accumulator clear to 0.
- data_ready_o is combinational:
  - 1 if the next accepted beat would not complete a group (count+1 < target for the latched or pending target).
  - Otherwise 1 only if the output register is empty or draining (!accumulated_data_valid_o || accumulated_data_ready_i).
  - Non-completing beats keep accumulating while the output is stalled.
- Simultaneous output drain and group completion on the same edge: the new word loads and valid stays 1, giving full throughput of one output per group with no bubbles.
- target=1: every accepted beat produces an output with keep = 0...01.
- last_i on the first beat of a group: one-word output, keep bit0 only.
- No zero-length outputs are ever produced.
- No combinational path from accumulated_data_ready_i to accumulated_data_o. A path to data_ready_o is permitted.

Test Plan:
- INPUT_WIDTH=8, MAX_WORDS=4, little, words_per_out_i=0, out_ready=1; beats 01,02,03,04 -> one output 0x04030201, keep 4'b1111, valid one cycle after the 04 beat.
- Same stimulus with ENDIAN="big" -> 0x01020304, keep 4'b1111.
- Little endian; beats A1, then A2 with last_i=1 -> 0x0000A2A1, keep 4'b0011. Next group 05..08 -> 0x08070605.
- Backpressure:
  - Hold accumulated_data_ready_i=0 after output 0x04030201; send 11,12,13,14.
  - 11..13 are accepted; data_ready_o=0 while 14 is offered.
  - Output stays 0x04030201 until ready; 14 is accepted on the drain edge; next output 0x14131211.
- Runtime length:
  - words_per_out_i=2; beats 21..24 -> 0x00002221 then 0x00002423, keep 4'b0011 each.
  - Changing words_per_out_i to 4 after beat 21 has no effect on that group.
- Reset mid-group: accept 31,32; pulse reset_n_i low asynchronously between edges -> all outputs 0 immediately. Then beats 10..13 -> 0x13121110, with no trace of 31/32.
- Random soak: 10000 cycles of random valid/ready/last. The bench scoreboard checks every accepted input appears exactly once in order with correct keep.

Source files
------------

// File: rtl/word_concatenator_stream.sv
`default_nettype none
// ============================================================================
//  Module   : word_concatenator_stream
//  Purpose  : Packs up to MAX_WORDS narrow input words into one wide output
//             word. Valid/ready handshakes on both sides, a group length that
//             can change between groups, early close via last_i, and a
//             per-slot keep mask on the output.
//  Revision : 1.0  - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i                     clock, rising edge
//    reset_n_i                 asynchronous active-low reset
//    words_per_out_i           group length (0 or > MAX_WORDS -> MAX_WORDS)
//    data_i / data_valid_i     input word and its valid
//    last_i                    closes the group after this beat
//    data_ready_o              input can be accepted this cycle
//    accumulated_data_o        packed output word
//    accumulated_keep_o        bit k set = group word k present (group order)
//    accumulated_data_valid_o  output valid
//    accumulated_data_ready_i  consumer accepts the output
// ============================================================================
module word_concatenator_stream #(
  parameter int    INPUT_WIDTH = 8,
  parameter int    MAX_WORDS   = 4,
  parameter string ENDIAN      = "little",
  parameter int    CNT_W       = $clog2(MAX_WORDS + 1)
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic [CNT_W-1:0]                 words_per_out_i,
  input  logic [INPUT_WIDTH-1:0]           data_i,
  input  logic                             data_valid_i,
  input  logic                             last_i,
  output logic                             data_ready_o,
  output logic [INPUT_WIDTH*MAX_WORDS-1:0] accumulated_data_o,
  output logic [MAX_WORDS-1:0]             accumulated_keep_o,
  output logic                             accumulated_data_valid_o,
  input  logic                             accumulated_data_ready_i
);

  localparam int               OUT_W   = INPUT_WIDTH * MAX_WORDS;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

  logic [CNT_W-1:0]     count_q, count_d;
  logic [CNT_W-1:0]     target_q, target_d;
  logic [OUT_W-1:0]     acc_data_q, acc_data_d;
  logic [MAX_WORDS-1:0] acc_keep_q, acc_keep_d;
  logic [OUT_W-1:0]     out_data_q, out_data_d;
  logic [MAX_WORDS-1:0] out_keep_q, out_keep_d;
  logic                 out_valid_q, out_valid_d;

  logic [CNT_W-1:0]     req_len;
  logic [CNT_W-1:0]     eff_target;
  logic [CNT_W-1:0]     slot_idx;
  logic [CNT_W:0]       count_inc;
  logic                 would_complete;
  logic                 out_free;
  logic                 accept;
  logic [OUT_W-1:0]     beat_data;
  logic [MAX_WORDS-1:0] beat_keep;

  // Physical slot for the next beat; keep always follows group order.
  generate
    if (ENDIAN == "big") begin : g_big
      assign slot_idx = MAX_CNT - CNT_W'(1) - count_q;
    end else begin : g_little
      assign slot_idx = count_q;
    end
  endgenerate

  always_comb begin
    req_len = words_per_out_i;
    if (words_per_out_i == '0 || words_per_out_i > MAX_CNT) begin
      req_len = MAX_CNT;
    end
    // The first beat of a group uses the live length; later beats the latched one.
    eff_target = (count_q == '0) ? req_len : target_q;
    count_inc  = {1'b0, count_q} + (CNT_W+1)'(1);
    // last_i closes the group too, so it must also respect output space.
    would_complete = (count_inc >= {1'b0, eff_target}) || last_i;
    out_free       = !out_valid_q || accumulated_data_ready_i;
    data_ready_o   = reset_n_i && (!would_complete || out_free);
    accept         = data_valid_i && data_ready_o;
  end

  // Accumulator contents as they would look with the current beat merged in.
  always_comb begin
    beat_data = acc_data_q;
    beat_keep = acc_keep_q;
    for (int k = 0; k < MAX_WORDS; k++) begin
      if (slot_idx == CNT_W'(k)) begin
        beat_data[k*INPUT_WIDTH +: INPUT_WIDTH] = data_i;
      end
      if (count_q == CNT_W'(k)) begin
        beat_keep[k] = 1'b1;
      end
    end
  end

  always_comb begin
    count_d     = count_q;
    target_d    = target_q;
    acc_data_d  = acc_data_q;
    acc_keep_d  = acc_keep_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_valid_d = out_valid_q;

    if (out_valid_q && accumulated_data_ready_i) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      if (count_q == '0) begin
        target_d = req_len;
      end
      if (would_complete) begin
        // Loading a new word overrides a same-edge drain: no bubble.
        out_data_d  = beat_data;
        out_keep_d  = beat_keep;
        out_valid_d = 1'b1;
        count_d     = '0;
        acc_data_d  = '0;
        acc_keep_d  = '0;
      end else begin
        count_d    = count_q + CNT_W'(1);
        acc_data_d = beat_data;
        acc_keep_d = beat_keep;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q     <= '0;
      target_q    <= '0;
      acc_data_q  <= '0;
      acc_keep_q  <= '0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      target_q    <= target_d;
      acc_data_q  <= acc_data_d;
      acc_keep_q  <= acc_keep_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign accumulated_data_o       = out_data_q;
  assign accumulated_keep_o       = out_keep_q;
  assign accumulated_data_valid_o = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_word_concatenator_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_word_concatenator_stream
//  Purpose  : Self-checking bench for word_concatenator_stream. A little- and
//             a big-endian instance share one stimulus stream; a queue-based
//             group model predicts ready, valid, data and keep every cycle.
//  Revision : 1.0  - initial release
// ============================================================================
module tb_word_concatenator_stream;

  logic        clk;
  logic        rst_n;
  logic [2:0]  wpo;
  logic [7:0]  din;
  logic        dv;
  logic        last;
  logic        out_ready;
  logic        rdy_l, rdy_b;
  logic [31:0] data_l, data_b;
  logic [3:0]  keep_l, keep_b;
  logic        val_l, val_b;

  word_concatenator_stream #(.INPUT_WIDTH(8), .MAX_WORDS(4), .ENDIAN("little")) dut_l (
    .clk_i(clk), .reset_n_i(rst_n), .words_per_out_i(wpo), .data_i(din),
    .data_valid_i(dv), .last_i(last), .data_ready_o(rdy_l),
    .accumulated_data_o(data_l), .accumulated_keep_o(keep_l),
    .accumulated_data_valid_o(val_l), .accumulated_data_ready_i(out_ready)
  );

  word_concatenator_stream #(.INPUT_WIDTH(8), .MAX_WORDS(4), .ENDIAN("big")) dut_b (
    .clk_i(clk), .reset_n_i(rst_n), .words_per_out_i(wpo), .data_i(din),
    .data_valid_i(dv), .last_i(last), .data_ready_o(rdy_b),
    .accumulated_data_o(data_b), .accumulated_keep_o(keep_b),
    .accumulated_data_valid_o(val_b), .accumulated_data_ready_i(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model state: beats of the open group, its target, and the output register.
  logic [7:0]  grp[$];
  int          tgt = 4;
  logic        ev = 1'b0;
  logic [31:0] ed_l = '0, ed_b = '0;
  logic [3:0]  ek = '0;
  int          model_words_out = 0;
  int          dut_words_out = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int sat_len(input int w);
    return (w == 0 || w > 4) ? 4 : w;
  endfunction

  task automatic model_reset();
    grp.delete();
    ev = 1'b0;
  endtask

  // Called just after a falling edge: drive, check, predict, advance one cycle.
  task automatic step(input bit v, input logic [7:0] d, input bit l, input int w, input bit r);
    int  pend_tgt;
    bit  wc, exp_rdy, acc, xfer;
    dv = v; din = d; last = l; wpo = w[2:0]; out_ready = r;
    #1;
    pend_tgt = (grp.size() == 0) ? sat_len(w) : tgt;
    wc       = (grp.size() + 1 >= pend_tgt) || l;
    exp_rdy  = !wc || !ev || r;
    chk("ready", {31'b0, rdy_l}, {31'b0, exp_rdy});
    chk("ready_big", {31'b0, rdy_b}, {31'b0, exp_rdy});
    chk("valid", {31'b0, val_l}, {31'b0, ev});
    chk("valid_big", {31'b0, val_b}, {31'b0, ev});
    if (ev) begin
      chk("data_little", data_l, ed_l);
      chk("data_big", data_b, ed_b);
      chk("keep", {28'b0, keep_l}, {28'b0, ek});
      chk("keep_big", {28'b0, keep_b}, {28'b0, ek});
    end
    if (val_l && r) dut_words_out += $countones(keep_l);
    acc  = v && exp_rdy;
    xfer = ev && r;
    if (xfer) model_words_out += $countones(ek);
    if (acc) begin
      if (grp.size() == 0) tgt = sat_len(w);
      grp.push_back(d);
      if (grp.size() == tgt || l) begin
        ed_l = '0; ed_b = '0; ek = '0;
        for (int k = 0; k < grp.size(); k++) begin
          ed_l[k*8 +: 8]     = grp[k];
          ed_b[(3-k)*8 +: 8] = grp[k];
          ek[k]              = 1'b1;
        end
        ev = 1'b1;
        grp.delete();
      end else if (xfer) begin
        ev = 1'b0;
      end
    end else if (xfer) begin
      ev = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Literal expectations that pin both the model and the DUTs.
  task automatic check_out(input string nm, input logic [31:0] el, input logic [31:0] eb,
                           input logic [3:0] k);
    chk({nm, "_valid"}, {31'b0, val_l}, 32'd1);
    chk({nm, "_data"}, data_l, el);
    chk({nm, "_data_big"}, data_b, eb);
    chk({nm, "_keep"}, {28'b0, keep_l}, {28'b0, k});
    chk({nm, "_model"}, ed_l, el);
  endtask

  initial begin
    rst_n = 1'b0; dv = 1'b0; din = '0; last = 1'b0; wpo = '0; out_ready = 1'b1;
    @(negedge clk);
    chk("reset_valid", {31'b0, val_l}, 32'd0);
    chk("reset_data", data_l, 32'd0);
    chk("reset_keep", {28'b0, keep_l}, 32'd0);
    chk("reset_ready", {31'b0, rdy_l}, 32'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Full group, both endians.
    step(1, 8'h01, 0, 0, 1); step(1, 8'h02, 0, 0, 1);
    step(1, 8'h03, 0, 0, 1); step(1, 8'h04, 0, 0, 1);
    check_out("full", 32'h04030201, 32'h01020304, 4'b1111);

    // Early close with last_i, then a fresh full group.
    step(1, 8'hA1, 0, 0, 1); step(1, 8'hA2, 1, 0, 1);
    check_out("last", 32'h0000A2A1, 32'hA1A20000, 4'b0011);
    step(1, 8'h05, 0, 0, 1); step(1, 8'h06, 0, 0, 1);
    step(1, 8'h07, 0, 0, 1); step(1, 8'h08, 0, 0, 1);
    check_out("after_last", 32'h08070605, 32'h05060708, 4'b1111);

    // Backpressure: partial beats keep flowing, completing beat waits.
    step(1, 8'h01, 0, 0, 1); step(1, 8'h02, 0, 0, 1);
    step(1, 8'h03, 0, 0, 1); step(1, 8'h04, 0, 0, 1);
    step(1, 8'h11, 0, 0, 0); step(1, 8'h12, 0, 0, 0); step(1, 8'h13, 0, 0, 0);
    check_out("stall_hold", 32'h04030201, 32'h01020304, 4'b1111);
    dv = 1'b1; din = 8'h14; last = 1'b0; out_ready = 1'b0; #1;
    chk("stall_ready_low", {31'b0, rdy_l}, 32'd0);
    step(1, 8'h14, 0, 0, 0);
    check_out("stall_hold2", 32'h04030201, 32'h01020304, 4'b1111);
    step(1, 8'h14, 0, 0, 1);
    check_out("drain_load", 32'h14131211, 32'h11121314, 4'b1111);

    // Runtime length, changed mid-group without effect.
    step(1, 8'h21, 0, 2, 1); step(1, 8'h22, 0, 4, 1);
    check_out("len2_a", 32'h00002221, 32'h21220000, 4'b0011);
    step(1, 8'h23, 0, 2, 1); step(1, 8'h24, 0, 2, 1);
    check_out("len2_b", 32'h00002423, 32'h23240000, 4'b0011);

    // target=1 produces single-word outputs.
    step(1, 8'h55, 0, 1, 1);
    check_out("len1", 32'h00000055, 32'h55000000, 4'b0001);

    // Asynchronous reset mid-group.
    step(1, 8'h31, 0, 0, 1); step(1, 8'h32, 0, 0, 1);
    dv = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("areset_valid", {31'b0, val_l}, 32'd0);
    chk("areset_data", data_l, 32'd0);
    chk("areset_keep", {28'b0, keep_l}, 32'd0);
    chk("areset_ready", {31'b0, rdy_l}, 32'd0);
    model_reset();
    #1 rst_n = 1'b1;
    @(negedge clk);
    step(1, 8'h10, 0, 0, 1); step(1, 8'h11, 0, 0, 1);
    step(1, 8'h12, 0, 0, 1); step(1, 8'h13, 0, 0, 1);
    check_out("post_reset", 32'h13121110, 32'h10111213, 4'b1111);

    // Random soak.
    for (int i = 0; i < 10000; i++) begin
      step(($urandom % 4) != 0, 8'($urandom), ($urandom % 5) == 0,
           int'($urandom % 8), ($urandom % 3) != 0);
    end
    for (int i = 0; i < 4; i++) step(0, 8'h00, 0, 0, 1);
    chk("words_out_total", dut_words_out, model_words_out);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
